// File: rtl/cube_pkg.sv
// cube_pkg: shared types and constants for the rotating-cube frame sequencer.
// Holds the sequencer state enum, the 12-entry cube edge table and the
// angle-advance helper. No ports.
package cube_pkg;

  localparam int NUM_EDGES = 12;
  localparam int NUM_VERTS = 8;

  typedef enum logic [2:0] {
    IDLE,
    ROTATE,
    CLEAR,
    DRAW_REQ,
    DRAW_WAIT,
    SWAP
  } seq_state_t;

  // Vertex index encodes the corner: bit0 = x, bit1 = y, bit2 = z.
  // Each entry is {v0, v1}; written in octal so each digit is one vertex.
  // Order: four X-direction edges, four Y-direction edges, four Z-direction edges.
  localparam logic [5:0] CUBE_EDGES [NUM_EDGES] = '{
    6'o01, 6'o23, 6'o45, 6'o67,
    6'o02, 6'o13, 6'o46, 6'o57,
    6'o04, 6'o15, 6'o26, 6'o37
  };

  function automatic logic [2:0] edge_start(input logic [3:0] idx);
    logic [5:0] e;
    e = CUBE_EDGES[idx];
    return e[5:3];
  endfunction

  function automatic logic [2:0] edge_end(input logic [3:0] idx);
    logic [5:0] e;
    e = CUBE_EDGES[idx];
    return e[2:0];
  endfunction

  // step < steps, so a single conditional subtract is enough to wrap.
  function automatic logic [8:0] theta_advance(input logic [8:0] theta,
                                               input int step,
                                               input int steps);
    int sum;
    sum = int'(theta) + step;
    if (sum >= steps) sum = sum - steps;
    return 9'(sum);
  endfunction

endpackage

// File: rtl/cube_frame_sequencer_fb_clear_scanner.sv
// fb_clear_scanner: (SIZE+1)x(SIZE+1) raster counter, x fastest, used to sweep
// the back buffer during a clear. Ports: clk, rst, start (sync restart at 0,0),
// en (advance one pixel), x/y (current address), last (address is SIZE,SIZE).
module fb_clear_scanner #(
  parameter int SIZE = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       en,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       last
);

  localparam logic [8:0] MAX = 9'(SIZE);

  assign last = (x == MAX) && (y == MAX);

  // Wrapping back to (0,0) after the last pixel leaves the scanner ready for
  // the next frame even without a start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == MAX) begin
        x <= '0;
        y <= last ? 9'd0 : y + 9'd1;
      end else begin
        x <= x + 9'd1;
      end
    end
  end

endmodule

// File: rtl/cube_frame_sequencer.sv
// cube_frame_sequencer: per-frame scheduler -- rotate vertices, clear back buffer,
// draw 12 cube edges, swap buffers and advance the angle.
// Ports: frame_start/rot_en in; rot_start/rot_done and theta_idx to rotation block;
// fb_we/fb_x/fb_y clear port; line_req/line_ack/edge_v0/edge_v1/line_done to line engine;
// buf_sel, busy, frame_ready, overrun status.
module cube_frame_sequencer
  import cube_pkg::*;
#(
  parameter int SIZE        = 120,
  parameter int ANGLE_STEPS = 360,
  parameter int THETA_STEP  = 1,
  parameter int FRAME_DIV   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       rot_en,
  output logic       rot_start,
  input  logic       rot_done,
  output logic [8:0] theta_idx,
  output logic       fb_we,
  output logic [8:0] fb_x,
  output logic [8:0] fb_y,
  output logic       line_req,
  input  logic       line_ack,
  output logic [2:0] edge_v0,
  output logic [2:0] edge_v1,
  input  logic       line_done,
  output logic       buf_sel,
  output logic       busy,
  output logic       frame_ready,
  output logic       overrun
);

  localparam int         DIV_W     = $clog2(FRAME_DIV + 1);
  localparam logic [3:0] LAST_EDGE = 4'(NUM_EDGES - 1);

  seq_state_t       state;
  logic [3:0]       edge_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             scan_last;

  // Scanner is held at the origin while rotating and advances only in CLEAR,
  // so its registers drive the clear address directly.
  fb_clear_scanner #(.SIZE(SIZE)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .start (state == ROTATE),
    .en    (state == CLEAR),
    .x     (fb_x),
    .y     (fb_y),
    .last  (scan_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rot_start   <= 1'b0;
      theta_idx   <= '0;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      fb_we       <= 1'b0;
      line_req    <= 1'b0;
      edge_v0     <= '0;
      edge_v1     <= '0;
      buf_sel     <= 1'b0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rot_start   <= 1'b0;
      frame_ready <= 1'b0;

      if (frame_start && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= ROTATE;
            rot_start <= 1'b1;
            busy      <= 1'b1;
          end
        end

        // rot_start is still high in the first ROTATE cycle; a rot_done seen
        // then belongs to the previous rotation and must not be taken.
        ROTATE: begin
          if (rot_done && !rot_start) begin
            state <= CLEAR;
            fb_we <= 1'b1;
          end
        end

        CLEAR: begin
          if (scan_last) begin
            state    <= DRAW_REQ;
            fb_we    <= 1'b0;
            line_req <= 1'b1;
            edge_v0  <= edge_start(edge_cnt);
            edge_v1  <= edge_end(edge_cnt);
          end
        end

        DRAW_REQ: begin
          if (line_ack) begin
            line_req <= 1'b0;
            state    <= DRAW_WAIT;
          end
        end

        // Only reachable one cycle after the ack, so a line_done coincident
        // with the ack was already dropped in DRAW_REQ.
        DRAW_WAIT: begin
          if (line_done) begin
            if (edge_cnt == LAST_EDGE) begin
              state <= SWAP;
            end else begin
              edge_cnt <= edge_cnt + 4'd1;
              edge_v0  <= edge_start(edge_cnt + 4'd1);
              edge_v1  <= edge_end(edge_cnt + 4'd1);
              line_req <= 1'b1;
              state    <= DRAW_REQ;
            end
          end
        end

        SWAP: begin
          buf_sel     <= ~buf_sel;
          frame_ready <= 1'b1;
          edge_cnt    <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
          if (rot_en) begin
            if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
              div_cnt   <= '0;
              theta_idx <= theta_advance(theta_idx, THETA_STEP, ANGLE_STEPS);
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_frame_sequencer.sv
// Directed self-checking bench for cube_frame_sequencer with SIZE=4, FRAME_DIV=2.
module tb_cube_frame_sequencer;
  import cube_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       rot_en = 1'b0;
  logic       rot_done = 1'b0;
  logic       line_ack = 1'b0;
  logic       line_done = 1'b0;
  logic       rot_start, fb_we, line_req, buf_sel, busy, frame_ready, overrun;
  logic [8:0] theta_idx, fb_x, fb_y;
  logic [2:0] edge_v0, edge_v1;

  int n_checks = 0;
  int n_fail = 0;

  // Per-frame observations gathered by run_frame.
  int rs_cyc, n_rs, n_wr, wr_bad, n_xfer, edge_bad, stable, fr_cyc, bulk_bad;
  bit wait_seen;

  // Expected edge order {v0,v1}, written out from the cube geometry.
  logic [5:0] exp_edges [12] = '{
    6'o01, 6'o23, 6'o45, 6'o67, 6'o02, 6'o13,
    6'o46, 6'o57, 6'o04, 6'o15, 6'o26, 6'o37
  };

  cube_frame_sequencer #(
    .SIZE(4), .ANGLE_STEPS(360), .THETA_STEP(1), .FRAME_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .rot_en(rot_en),
    .rot_start(rot_start), .rot_done(rot_done), .theta_idx(theta_idx),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .line_req(line_req), .line_ack(line_ack),
    .edge_v0(edge_v0), .edge_v1(edge_v1), .line_done(line_done),
    .buf_sel(buf_sel), .busy(busy), .frame_ready(frame_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    chk({tag, "_rot_start"}, rot_start, 0);
    chk({tag, "_theta"}, theta_idx, 0);
    chk({tag, "_fb_we"}, fb_we, 0);
    chk({tag, "_fb_xy"}, {fb_x, fb_y}, 0);
    chk({tag, "_line_req"}, line_req, 0);
    chk({tag, "_edge"}, {edge_v0, edge_v1}, 0);
    chk({tag, "_buf_sel"}, buf_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_ready"}, frame_ready, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // Runs one frame with zero-wait responders. Optional: hold ack on edge
  // hold_edge for hold_n cycles; inject frame_start in CLEAR and SWAP;
  // reset during DRAW_WAIT of abort_edge. Cycle 0 is the frame_start cycle.
  task automatic run_frame(input int hold_edge, input int hold_n,
                           input bit fs_extra, input int abort_edge);
    int cyc, ex, ey, held;
    bit prev_rs, prev_xfer, xfer;
    rs_cyc = -1; n_rs = 0; n_wr = 0; wr_bad = 0; n_xfer = 0; edge_bad = 0;
    stable = 0; fr_cyc = -1; wait_seen = 0;
    ex = 0; ey = 0; held = 0; prev_rs = 0; prev_xfer = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (rot_start) begin
        n_rs++;
        if (rs_cyc < 0) rs_cyc = cyc;
      end
      if (fb_we) begin
        if (fb_x !== 9'(ex) || fb_y !== 9'(ey)) wr_bad++;
        n_wr++;
        if (ex == 4) begin ex = 0; ey++; end else ex++;
      end
      if (frame_ready) begin
        fr_cyc = cyc;
        break;
      end
      if (abort_edge >= 0 && prev_xfer && n_xfer == abort_edge + 1) begin
        wait_seen = (dut.state == DRAW_WAIT);
        rot_done = 0; line_ack = 0; line_done = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        break;
      end
      frame_start = fs_extra && ((fb_we && n_wr == 6) || dut.state == SWAP);
      rot_done  = prev_rs;
      prev_rs   = rot_start;
      line_done = prev_xfer;
      line_ack  = line_req;
      if (line_req && n_xfer == hold_edge) begin
        if (edge_v0 === 3'd6 && edge_v1 === 3'd7) stable++;
        if (held < hold_n) begin
          line_ack = 1'b0;
          held++;
        end
      end
      xfer = line_req && line_ack;
      if (xfer) begin
        if (n_xfer >= 12 || {edge_v0, edge_v1} !== exp_edges[n_xfer]) edge_bad++;
        n_xfer++;
      end
      prev_xfer = xfer;
      tick();
      cyc++;
    end
    frame_start = 0; rot_done = 0; line_ack = 0; line_done = 0;
  endtask

  initial begin
    // Power-on reset.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_outputs("por");

    // Test 1: reset asserted mid-clear.
    frame_start = 1'b1; rot_done = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t1_in_clear", fb_we, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t1_rst");
    tick();
    rst = 1'b0; rot_done = 1'b0;
    tick();

    // Test 2: nominal frame, zero-wait responders.
    run_frame(-1, 0, 0, -1);
    chk("t2_rot_start_cyc", rs_cyc, 1);
    chk("t2_rot_start_cnt", n_rs, 1);
    chk("t2_writes", n_wr, 25);
    chk("t2_write_order_bad", wr_bad, 0);
    chk("t2_xfers", n_xfer, 12);
    chk("t2_edge_order_bad", edge_bad, 0);
    chk("t2_frame_ready_cyc", fr_cyc, 53);
    chk("t2_buf_sel", buf_sel, 1);
    chk("t2_theta", theta_idx, 0);
    tick();
    chk("t2_frame_ready_pulse", frame_ready, 0);
    chk("t2_busy_idle", busy, 0);

    // Test 3: ack held off for 5 cycles on edge 3.
    run_frame(3, 5, 0, -1);
    chk("t3_stable_cycles", stable, 6);
    chk("t3_xfers", n_xfer, 12);
    chk("t3_edge_order_bad", edge_bad, 0);
    chk("t3_frame_ready_cyc", fr_cyc, 58);
    chk("t3_buf_sel", buf_sel, 0);

    // Test 4: frame_start during CLEAR and during SWAP.
    run_frame(-1, 0, 1, -1);
    chk("t4_overrun", overrun, 1);
    chk("t4_rot_start_cnt", n_rs, 1);
    chk("t4_writes", n_wr, 25);
    chk("t4_frame_ready_cyc", fr_cyc, 53);
    chk("t4_buf_sel", buf_sel, 1);
    tick(); tick(); tick();
    chk("t4_no_restart", rot_start, 0);
    chk("t4_idle", busy, 0);
    chk("t4_overrun_sticky", overrun, 1);

    // Test 6: reset in DRAW_WAIT of edge 7, then a clean frame.
    run_frame(-1, 0, 0, 7);
    chk("t6_was_draw_wait", wait_seen, 1);
    chk("t6_xfers_before_rst", n_xfer, 8);
    chk_reset_outputs("t6_rst");
    tick();
    run_frame(-1, 0, 0, -1);
    chk("t6_rot_start_cyc", rs_cyc, 1);
    chk("t6_writes", n_wr, 25);
    chk("t6_write_order_bad", wr_bad, 0);
    chk("t6_xfers", n_xfer, 12);
    chk("t6_edge_order_bad", edge_bad, 0);
    chk("t6_frame_ready_cyc", fr_cyc, 53);
    chk("t6_buf_sel", buf_sel, 1);

    // Test 5: angle advance with FRAME_DIV=2. 716 frames bring 0 to 358.
    rot_en = 1'b1;
    bulk_bad = 0;
    for (int i = 0; i < 716; i++) begin
      run_frame(-1, 0, 0, -1);
      if (fr_cyc != 53) bulk_bad++;
    end
    chk("t5_bulk_frames_bad", bulk_bad, 0);
    chk("t5_theta_358", theta_idx, 358);
    run_frame(-1, 0, 0, -1);
    chk("t5_theta_div_hold", theta_idx, 358);
    run_frame(-1, 0, 0, -1);
    chk("t5_theta_359", theta_idx, 359);
    run_frame(-1, 0, 0, -1);
    chk("t5_theta_359_hold", theta_idx, 359);
    run_frame(-1, 0, 0, -1);
    chk("t5_theta_wrap_0", theta_idx, 0);
    rot_en = 1'b0;
    run_frame(-1, 0, 0, -1);
    run_frame(-1, 0, 0, -1);
    chk("t5_theta_frozen", theta_idx, 0);
    chk("t5_frozen_frame_cyc", fr_cyc, 53);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
